// File: rtl/inst_queue.sv
`default_nettype none
// ============================================================================
// Module   : inst_queue
// Purpose  : Circular {pc, inst} FIFO between fetch and decode with flush,
//            almost-full back-pressure and optional empty-queue bypass.
// Revision : 1.0 - initial release
// ============================================================================
module inst_queue #(
    parameter int DEPTH        = 8,
    parameter int INST_WIDTH   = 32,
    parameter int PC_WIDTH     = 32,
    parameter int AFULL_THRESH = DEPTH - 2,
    parameter int BYPASS       = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    enq_valid,
    output logic                    enq_ready,
    input  logic [INST_WIDTH-1:0]   enq_inst,
    input  logic [PC_WIDTH-1:0]     enq_pc,
    output logic                    deq_valid,
    input  logic                    deq_ready,
    output logic [INST_WIDTH-1:0]   deq_inst,
    output logic [PC_WIDTH-1:0]     deq_pc,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    empty,
    output logic                    full,
    output logic                    almost_full
);

    localparam int c_PTR_W   = $clog2(DEPTH);
    localparam int c_CNT_W   = c_PTR_W + 1;
    localparam int c_ENTRY_W = PC_WIDTH + INST_WIDTH;

    localparam logic [c_CNT_W-1:0] c_DEPTH     = c_CNT_W'(DEPTH);
    localparam logic [c_CNT_W-1:0] c_AFULL     = c_CNT_W'(AFULL_THRESH);
    localparam logic [c_CNT_W-1:0] c_CNT_ZERO  = '0;
    localparam logic [c_PTR_W-1:0] c_PTR_ZERO  = '0;
    localparam logic [c_PTR_W-1:0] c_PTR_ONE   = c_PTR_W'(1);

    logic [c_ENTRY_W-1:0] r_mem [DEPTH];
    logic [c_PTR_W-1:0]   r_head;
    logic [c_PTR_W-1:0]   r_tail;
    logic [c_CNT_W-1:0]   r_count;

    logic                 w_empty;
    logic                 w_full;
    logic                 w_bypass;
    logic                 w_enq_fire;
    logic                 w_deq_fire;
    logic                 w_pass_through;
    logic                 w_push;
    logic                 w_pop;
    logic [c_ENTRY_W-1:0] w_head_entry;
    logic [c_ENTRY_W-1:0] w_deq_entry;

    // Status flags come from the count register only, never pointer equality.
    assign w_empty     = (r_count == c_CNT_ZERO);
    assign w_full      = (r_count == c_DEPTH);
    assign count       = r_count;
    assign empty       = w_empty;
    assign full        = w_full;
    assign almost_full = (r_count >= c_AFULL);

    // No path from deq_ready: a push into a full queue is refused even on a pop.
    assign enq_ready  = ~w_full & ~flush;
    assign deq_valid  = (~w_empty | w_bypass) & ~flush;
    assign w_enq_fire = enq_valid & enq_ready;
    assign w_deq_fire = deq_valid & deq_ready;

    // A bypassed entry that decode takes immediately never touches storage.
    assign w_pass_through = w_bypass & deq_ready;
    assign w_push         = w_enq_fire & ~w_pass_through;
    assign w_pop          = w_deq_fire & ~w_pass_through;

    assign w_head_entry = r_mem[r_head];

    generate
        if (BYPASS != 0) begin : g_bypass
            assign w_bypass    = w_empty & enq_valid & ~flush;
            assign w_deq_entry = w_bypass ? {enq_pc, enq_inst} : w_head_entry;
        end else begin : g_no_bypass
            assign w_bypass    = 1'b0;
            assign w_deq_entry = rst ? '0 : w_head_entry;
        end
    endgenerate

    assign deq_pc   = w_deq_entry[c_ENTRY_W-1:INST_WIDTH];
    assign deq_inst = w_deq_entry[INST_WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_tail] <= {enq_pc, enq_inst};
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_head  <= c_PTR_ZERO;
            r_tail  <= c_PTR_ZERO;
            r_count <= c_CNT_ZERO;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + c_PTR_ONE;
            end
            if (w_pop) begin
                r_head <= r_head + c_PTR_ONE;
            end
            r_count <= r_count + c_CNT_W'(w_push) - c_CNT_W'(w_pop);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_inst_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_inst_queue
// Purpose  : Directed self-checking bench for inst_queue (plain and bypass).
// Revision : 1.0 - initial release
// ============================================================================
module tb_inst_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;

    logic        enq_valid, enq_ready, deq_valid, deq_ready;
    logic [31:0] enq_inst, enq_pc, deq_inst, deq_pc;
    logic [3:0]  count;
    logic        empty, full, almost_full;

    logic        b_enq_valid, b_enq_ready, b_deq_valid, b_deq_ready;
    logic [31:0] b_enq_inst, b_enq_pc, b_deq_inst, b_deq_pc;
    logic [3:0]  b_count;
    logic        b_empty, b_full, b_almost_full;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    inst_queue #(.DEPTH(8), .INST_WIDTH(32), .PC_WIDTH(32), .AFULL_THRESH(6), .BYPASS(0)) u_dut (
        .clk(clk), .rst(rst), .flush(flush),
        .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_inst(enq_inst), .enq_pc(enq_pc),
        .deq_valid(deq_valid), .deq_ready(deq_ready), .deq_inst(deq_inst), .deq_pc(deq_pc),
        .count(count), .empty(empty), .full(full), .almost_full(almost_full)
    );

    inst_queue #(.DEPTH(8), .INST_WIDTH(32), .PC_WIDTH(32), .AFULL_THRESH(6), .BYPASS(1)) u_dut_byp (
        .clk(clk), .rst(rst), .flush(flush),
        .enq_valid(b_enq_valid), .enq_ready(b_enq_ready), .enq_inst(b_enq_inst), .enq_pc(b_enq_pc),
        .deq_valid(b_deq_valid), .deq_ready(b_deq_ready), .deq_inst(b_deq_inst), .deq_pc(b_deq_pc),
        .count(b_count), .empty(b_empty), .full(b_full), .almost_full(b_almost_full)
    );

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return pc ^ 32'hFFFF_0000;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle();
        enq_valid = 1'b0; deq_ready = 1'b0; flush = 1'b0;
    endtask

    task automatic push(input logic [31:0] pc);
        enq_valid = 1'b1; enq_pc = pc; enq_inst = inst_of(pc); deq_ready = 1'b0;
        settle();
        chk("push_ready", {63'd0, enq_ready}, 64'd1);
        tick();
        enq_valid = 1'b0;
    endtask

    task automatic pop_expect(input logic [31:0] pc);
        enq_valid = 1'b0; deq_ready = 1'b1;
        settle();
        chk("pop_valid", {63'd0, deq_valid}, 64'd1);
        chk("pop_pc", {32'd0, deq_pc}, {32'd0, pc});
        chk("pop_inst", {32'd0, deq_inst}, {32'd0, inst_of(pc)});
        tick();
        deq_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0;
        enq_valid = 1'b0; deq_ready = 1'b0; enq_pc = '0; enq_inst = '0;
        b_enq_valid = 1'b0; b_deq_ready = 1'b0; b_enq_pc = '0; b_enq_inst = '0;
        tick();
        settle();
        chk("rst_deq_inst_zero", {32'd0, deq_inst}, 64'd0);
        chk("rst_deq_pc_zero", {32'd0, deq_pc}, 64'd0);
        rst = 1'b0;
        settle();
        chk("rst_count", {60'd0, count}, 64'd0);
        chk("rst_empty", {63'd0, empty}, 64'd1);
        chk("rst_full", {63'd0, full}, 64'd0);
        chk("rst_afull", {63'd0, almost_full}, 64'd0);
        chk("rst_deq_valid", {63'd0, deq_valid}, 64'd0);

        // Fill to full, watching count and almost_full on the way.
        for (int i = 0; i < 8; i++) begin
            enq_valid = 1'b1; enq_pc = 32'h1000 + 32'(4 * i); enq_inst = inst_of(enq_pc);
            settle();
            chk("fill_count", {60'd0, count}, 64'(i));
            chk("fill_afull", {63'd0, almost_full}, (i >= 6) ? 64'd1 : 64'd0);
            chk("fill_ready", {63'd0, enq_ready}, 64'd1);
            tick();
        end
        enq_pc = 32'h1020; enq_inst = inst_of(enq_pc);
        settle();
        chk("full_count", {60'd0, count}, 64'd8);
        chk("full_flag", {63'd0, full}, 64'd1);
        chk("full_afull", {63'd0, almost_full}, 64'd1);
        chk("full_enq_ready", {63'd0, enq_ready}, 64'd0);
        tick();
        enq_valid = 1'b0;
        for (int i = 0; i < 8; i++) pop_expect(32'h1000 + 32'(4 * i));
        settle();
        chk("drain_empty", {63'd0, empty}, 64'd1);
        chk("drain_deq_valid", {63'd0, deq_valid}, 64'd0);

        // Steady-state push+pop with 3 entries resident, crossing pointer wrap.
        for (int i = 0; i < 3; i++) push(32'h1100 + 32'(4 * i));
        for (int k = 0; k < 20; k++) begin
            enq_valid = 1'b1; enq_pc = 32'h110C + 32'(4 * k); enq_inst = inst_of(enq_pc);
            deq_ready = 1'b1;
            settle();
            chk("stream_pc", {32'd0, deq_pc}, {32'd0, 32'h1100 + 32'(4 * k)});
            chk("stream_count", {60'd0, count}, 64'd3);
            tick();
        end
        idle();
        settle();
        chk("stream_count_end", {60'd0, count}, 64'd3);
        for (int i = 0; i < 3; i++) pop_expect(32'h1150 + 32'(4 * i));

        // Full queue with simultaneous push and pop: push refused.
        for (int i = 0; i < 8; i++) push(32'h1200 + 32'(4 * i));
        enq_valid = 1'b1; enq_pc = 32'h1220; enq_inst = inst_of(enq_pc); deq_ready = 1'b1;
        settle();
        chk("fullpp_enq_ready", {63'd0, enq_ready}, 64'd0);
        chk("fullpp_deq_pc", {32'd0, deq_pc}, 64'h1200);
        tick();
        deq_ready = 1'b0;
        settle();
        chk("fullpp_count7", {60'd0, count}, 64'd7);
        chk("fullpp_retry_ready", {63'd0, enq_ready}, 64'd1);
        tick();
        enq_valid = 1'b0;
        settle();
        chk("fullpp_count8", {60'd0, count}, 64'd8);
        for (int i = 1; i < 9; i++) pop_expect(32'h1200 + 32'(4 * i));

        // Flush with 5 entries while pushing and popping.
        for (int i = 0; i < 5; i++) push(32'h1300 + 32'(4 * i));
        flush = 1'b1; enq_valid = 1'b1; enq_pc = 32'h13F0; enq_inst = inst_of(enq_pc); deq_ready = 1'b1;
        settle();
        chk("flush_enq_ready", {63'd0, enq_ready}, 64'd0);
        chk("flush_deq_valid", {63'd0, deq_valid}, 64'd0);
        tick();
        settle();
        chk("flush_held_count", {60'd0, count}, 64'd0);
        tick();
        idle();
        settle();
        chk("flush_count", {60'd0, count}, 64'd0);
        chk("flush_empty", {63'd0, empty}, 64'd1);
        push(32'h2000);
        pop_expect(32'h2000);

        // Reset mid-operation with a simultaneous enqueue.
        for (int i = 0; i < 4; i++) push(32'h1400 + 32'(4 * i));
        rst = 1'b1; enq_valid = 1'b1; enq_pc = 32'h1500; enq_inst = inst_of(enq_pc);
        tick();
        rst = 1'b0; enq_valid = 1'b0;
        settle();
        chk("midrst_count", {60'd0, count}, 64'd0);
        chk("midrst_deq_valid", {63'd0, deq_valid}, 64'd0);
        push(32'h1600);
        pop_expect(32'h1600);
        settle();
        chk("midrst_final_empty", {63'd0, empty}, 64'd1);

        // Bypass instance: zero-latency pass-through, then stored path.
        b_enq_valid = 1'b1; b_enq_pc = 32'h3000; b_enq_inst = inst_of(32'h3000); b_deq_ready = 1'b1;
        settle();
        chk("byp_deq_valid", {63'd0, b_deq_valid}, 64'd1);
        chk("byp_deq_pc", {32'd0, b_deq_pc}, 64'h3000);
        chk("byp_deq_inst", {32'd0, b_deq_inst}, {32'd0, inst_of(32'h3000)});
        tick();
        b_deq_ready = 1'b0;
        settle();
        chk("byp_count0", {60'd0, b_count}, 64'd0);
        chk("byp_hold_pc", {32'd0, b_deq_pc}, 64'h3000);
        tick();
        b_enq_valid = 1'b0; b_deq_ready = 1'b1;
        settle();
        chk("byp_count1", {60'd0, b_count}, 64'd1);
        chk("byp_stored_valid", {63'd0, b_deq_valid}, 64'd1);
        chk("byp_stored_pc", {32'd0, b_deq_pc}, 64'h3000);
        tick();
        settle();
        chk("byp_drained", {60'd0, b_count}, 64'd0);
        b_enq_valid = 1'b1; b_enq_pc = 32'h3100; b_enq_inst = inst_of(32'h3100); b_deq_ready = 1'b0;
        tick();
        b_enq_pc = 32'h3104; b_enq_inst = inst_of(32'h3104); b_deq_ready = 1'b1;
        settle();
        chk("byp_order_pc", {32'd0, b_deq_pc}, 64'h3100);
        tick();
        b_enq_valid = 1'b0;
        settle();
        chk("byp_order_count", {60'd0, b_count}, 64'd1);
        chk("byp_order_next", {32'd0, b_deq_pc}, 64'h3104);
        tick();
        b_deq_ready = 1'b0;
        settle();
        chk("byp_order_empty", {63'd0, b_empty}, 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/inst_queue.md
Name: inst_queue

Overview:
- Parametrised circular FIFO between the fetch stage and decode. Carries {pc, inst} pairs from the I-cache response path to the decode stage.
- Provides valid/ready handshakes on both sides and an occupancy count.
- Provides an almost-full threshold so fetch stops issuing imem requests early enough to absorb in-flight responses.
- A single-cycle flush discards all entries on branch mispredict. Optional empty-queue bypass mode gives zero-latency fetch-to-decode.

Parameters:
- DEPTH, 8, number of entries; power of two, >= 2.
- INST_WIDTH, 32, instruction field width.
- PC_WIDTH, 32, PC field width.
- AFULL_THRESH, DEPTH-2, almost_full asserts when count >= AFULL_THRESH; legal range 1..DEPTH.
- BYPASS, 0, 1 = enqueue data visible at dequeue in the same cycle when queue is empty.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  reset; synchronous, active-high.
- flush  input  1  discard all contents (mispredict).
- enq_valid  input  1  fetch presents an entry.
- enq_ready  output  1  queue accepts the entry this cycle.
- enq_inst  input  INST_WIDTH  instruction in.
- enq_pc  input  PC_WIDTH  PC in.
- deq_valid  output  1  head entry available.
- deq_ready  input  1  decode consumes head (low during backend stall).
- deq_inst  output  INST_WIDTH  head instruction.
- deq_pc  output  PC_WIDTH  head PC.
- count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- empty  output  1  count == 0.
- full  output  1  count == DEPTH.
- almost_full  output  1  count >= AFULL_THRESH.

Behaviour:
- Reset: head=0, tail=0, count=0, so empty=1, full=0, almost_full=0, deq_valid=0. Storage contents are don't-care.
  - BYPASS=0: deq_inst/deq_pc = 0 during reset.
  - Reset mid-operation discards everything exactly like flush and takes priority over flush and enq.
- State:
  - head and tail pointers, $clog2(DEPTH) bits each, wrap modulo DEPTH naturally.
  - Separate count register; empty/full derive from count, never from pointer equality alone.
- Handshakes:
  - enq_fire = enq_valid & enq_ready; deq_fire = deq_valid & deq_ready.
  - enq_ready = ~full & ~flush. Registered-state only: no combinational path from deq_ready, so a push to a full queue is refused even if a pop occurs the same cycle.
  - deq_valid = ~empty & ~flush (BYPASS=0). deq_inst/deq_pc = mem[head], driven combinationally from registered state.
- Write/read:
  - enq_fire writes mem[tail], tail+1. deq_fire advances head+1.
  - Simultaneous enq_fire and deq_fire on a non-empty queue: count unchanged, both pointers advance.
- Latency (BYPASS=0): an entry enqueued in cycle N is visible at dequeue in cycle N+1 at the earliest.
- BYPASS=1, when count==0 and enq_valid=1:
  - deq_valid=1 and deq_inst/deq_pc = enq_inst/enq_pc combinationally.
  - If deq_ready=1, the entry is consumed and not stored: pointers and count unchanged.
  - Otherwise it is written normally.
  - When count>0, bypass is inactive, preserving order.
- Flush:
  - Next cycle head=tail=0 and count=0.
  - During the flush cycle, enq and deq are both blocked (enq_ready=0, deq_valid=0), so a same-cycle pop or push is dropped. Flush wins over all simultaneous events.
  - Held flush keeps the queue empty.
- almost_full is purely from registered count. Fetch must stop issuing new imem requests while almost_full=1.
- Wrap-around: after DEPTH pushes and pops interleaved, pointers return to 0 with FIFO order intact.
- Overflow is impossible by construction. enq_valid while full is legal and is held off by enq_ready=0; data must be held by the producer.
- Pop when empty (deq_ready=1, deq_valid=0) is a no-op.

Test Plan:
- Reset, then push pc 0x1000..0x101C (inst = pc ^ 0xFFFF_0000), no pops → count=8, full=1, almost_full=1 from count 6, enq_ready=0. Then pop 8 → pcs dequeue in order 0x1000..0x101C, empty=1.
- Continuous push+pop every cycle for 20 cycles after prefill of 3 (BYPASS=0) → count stays 3, dequeued pc sequence strictly increasing by 4, pointer wrap at entry 8 and 16 transparent.
- Full queue, enq_valid=1 and deq_ready=1 same cycle → head popped, enq refused (enq_ready=0), count 8→7; next cycle enq accepted, count 8.
- Queue holding 5 entries, flush=1 with enq_valid=1 and deq_ready=1 → no deq_fire that cycle, next cycle count=0, empty=1. Push pc 0x2000 → it is the next dequeued pc.
- BYPASS=1, empty, enq pc 0x3000 with deq_ready=1 → deq_valid=1 and deq_pc=0x3000 same cycle, count stays 0. Repeat with deq_ready=0 → count=1, 0x3000 dequeued next cycle.
- rst asserted for one cycle with count=4 during simultaneous enq → count=0, deq_valid=0, the enqueued entry is lost.
